pipelined_fast_adder: RTL

Parametrised, pipelined add/subtract unit that generalises the team's 32-bit fast adders (carry-lookahead, carry-skip, carry-select) to arbitrary width. It splits a WIDTH-bit add into WIDTH/BLOCK carry-lookahead slices, with one slice per pipeline stage, and carries the partial carry forward in registers. It adds a subtract mode, a signed-overflow flag and a valid/ready stream interface. It sits between operand-producing logic and any consumer that needs one add/sub result per clock at a high clock rate.

---
 rtl/fast_adder_pkg.sv | 24 ++
 rtl/cla_block.sv | 60 ++++++
 rtl/pipelined_fast_adder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fast_adder_pkg.sv
// Shared definitions for the fast-adder family.
//   DEF_WIDTH / DEF_BLOCK : default operand width and lookahead slice width
//   calc_nstage()         : number of pipeline stages (one slice per stage, >= 1)
//   gen_bit() / prop_bit(): per-bit carry generate / propagate terms
package fast_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  function automatic int calc_nstage(input int width, input int block);
    int n;
    n = (block > 0) ? width / block : 1;
    return (n < 1) ? 1 : n;
  endfunction

  function automatic logic gen_bit(input logic x, input logic y);
    return x & y;
  endfunction

  function automatic logic prop_bit(input logic x, input logic y);
    return x ^ y;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice.
//   a, b   : slice operands
//   cin    : slice carry-in
//   sum    : slice sum
//   cout   : slice carry-out
//   grp_p  : group propagate (all bits propagate)
//   grp_g  : group generate (carry out assuming cin = 0)
module cla_block
  import fast_adder_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;

  always_comb begin
    p = '0;
    g = '0;
    for (int i = 0; i < BLOCK; i++) begin
      p[i] = prop_bit(a[i], b[i]);
      g[i] = gen_bit(a[i], b[i]);
    end
  end

  // Each carry is a flat sum of products built straight from g/p and cin:
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..1]g[0] | p[i..0]cin
  // so no carry depends on another carry (true lookahead, not ripple).
  always_comb begin
    logic run_p;
    logic cg;
    c     = '0;
    c[0]  = cin;
    grp_g = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      cg    = g[i];
      run_p = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cg    = cg | (run_p & g[j]);
        run_p = run_p & p[j];
      end
      if (i == BLOCK - 1) grp_g = cg;
      c[i+1] = cg | (run_p & cin);
    end
  end

  assign sum   = p ^ c[BLOCK-1:0];
  assign cout  = c[BLOCK];
  assign grp_p = &p;

endmodule

// File: rtl/pipelined_fast_adder.sv
// Pipelined add/subtract unit: WIDTH-bit add split into NSTAGE = WIDTH/BLOCK
// lookahead slices, one slice per stage, with valid/ready stream handshake.
//   clk, rst            : clock, async active-high reset
//   in_valid / in_ready : operand handshake (in_ready = pipeline advances)
//   a, b, cin, sub      : operands; sub=1 gives a-b (cin ignored)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry-out (no-borrow on sub), signed overflow
module pipelined_fast_adder
  import fast_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = calc_nstage(WIDTH, BLOCK);

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("pipelined_fast_adder: WIDTH (%0d) must be a multiple of BLOCK (%0d)",
           WIDTH, BLOCK);
  end

  // One pipeline register. Operand fields travel whole; each stage only
  // reads its own slice, and the final stage's copy is dead.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [NSTAGE:0]  vld_pipe;
  logic [NSTAGE-1:0] unused_grp_p;
  logic [NSTAGE-1:0] unused_grp_g;
  logic              unused_tail;
  stage_t            stage_q [NSTAGE];
  stage_t            last;

  // Global enable: whole pipe moves unless the head result is blocked.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;

  assign vld_pipe[0] = accept;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [BLOCK-1:0] slice_sum;
    logic             slice_cout;

    if (k == 0) begin : g_head
      // Non-accepted cycles still load operands but with vld=0 (bubble).
      always_comb begin
        src       = '0;
        src.vld   = accept;
        src.a     = a;
        src.b     = b_eff;
        src.c     = c_eff;
        src.a_msb = a[WIDTH-1];
        src.b_msb = b_eff[WIDTH-1];
      end
    end else begin : g_body
      assign src = stage_q[k-1];
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a     (src.a[k*BLOCK +: BLOCK]),
      .b     (src.b[k*BLOCK +: BLOCK]),
      .cin   (src.c),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .grp_p (unused_grp_p[k]),
      .grp_g (unused_grp_g[k])
    );

    always_comb begin
      nxt                      = src;
      nxt.sum[k*BLOCK +: BLOCK] = slice_sum;
      nxt.c                    = slice_cout;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          stage_q[k] <= '0;
      else if (advance) stage_q[k] <= nxt;
    end

    assign vld_pipe[k+1] = stage_q[k].vld;
  end

  assign last      = stage_q[NSTAGE-1];
  assign out_valid = vld_pipe[NSTAGE];
  assign sum       = last.sum;
  assign cout      = last.c;
  // Overflow: operands of equal sign yielding a result of the other sign.
  assign ovf       = (last.a_msb == last.b_msb) && (last.sum[WIDTH-1] != last.a_msb);

  // Group P/G are reserved for skip/select variants; final operand copy is dead.
  assign unused_tail = ^{unused_grp_p, unused_grp_g, last.a, last.b};

endmodule
